// File: rtl/motor_driver.sv
// Two-wheel motor driver: shared PWM with soft ramp up/down, a dead-time
// gap before any direction change, and a level-sensitive emergency stop.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | no drive, duty 0, waiting for a non-STOP command
//   RAMP_UP   | duty climbs by RAMP_STEP per PWM period towards DUTY_MAX
//   RUN       | duty held at DUTY_MAX in the latched direction
//   RAMP_DOWN | duty falls by RAMP_STEP per PWM period towards 0
//   DEAD      | zero drive for DEAD_CYCLES cycles before returning to IDLE
module motor_driver #(
  parameter int unsigned PWM_PERIOD  = 1000,
  parameter int unsigned DUTY_MAX    = 800,
  parameter int unsigned RAMP_STEP   = 50,
  parameter int unsigned DEAD_CYCLES = 5000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [4:0]  motor_state,
  input  logic        overwrite,
  output logic        pwm_l,
  output logic        pwm_r,
  output logic        dir_l,
  output logic        dir_r,
  output logic [15:0] duty,
  output logic [2:0]  drive_state,
  output logic        busy
);

  localparam logic [15:0] PCNT_LAST = 16'(PWM_PERIOD - 1);
  localparam logic [15:0] DUTY_TOP  = 16'(DUTY_MAX);
  localparam logic [15:0] STEP      = 16'(RAMP_STEP);
  // A zero dead time still spends one cycle in DEAD so the counter compare stays simple.
  localparam logic [15:0] DEAD_LAST = (DEAD_CYCLES > 0) ? 16'(DEAD_CYCLES - 1) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN       = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_DEAD      = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] pcnt_q;
  logic [15:0] duty_q;
  logic [15:0] dead_cnt_q;
  logic        dir_l_q;
  logic        dir_r_q;
  logic        busy_q;
  logic        pwm_l_q;
  logic        pwm_r_q;

  logic        wrap;
  logic        tgt_valid_d;
  logic [1:0]  tgt_dir_d;
  logic        tgt_match;
  logic [16:0] up_sum;
  logic [15:0] duty_up_d;
  logic [15:0] duty_dn_d;
  logic        drive_en_d;

  assign wrap = (pcnt_q == PCNT_LAST);

  // Decode the robot command into a {dir_l, dir_r} target; unknown codes mean STOP.
  always_comb begin
    tgt_valid_d = 1'b1;
    tgt_dir_d   = 2'b11;
    case (motor_state)
      5'd1:    tgt_dir_d = 2'b11;
      5'd2:    tgt_dir_d = 2'b01;
      5'd3:    tgt_dir_d = 2'b10;
      default: tgt_valid_d = 1'b0;
    endcase
  end

  // STOP never matches, so it always pulls a moving motor into RAMP_DOWN.
  assign tgt_match = tgt_valid_d && (tgt_dir_d == {dir_l_q, dir_r_q});

  // Saturating ramp arithmetic; the 17-bit sum keeps the clamp correct near 16'hFFFF.
  always_comb begin
    up_sum    = {1'b0, duty_q} + {1'b0, STEP};
    duty_up_d = (up_sum >= {1'b0, DUTY_TOP}) ? DUTY_TOP : up_sum[15:0];
    duty_dn_d = (duty_q > STEP) ? (duty_q - STEP) : 16'd0;
  end

  // PWM compare is only honoured in the driving states and is killed by overwrite at once.
  always_comb begin
    drive_en_d = 1'b0;
    if (!overwrite &&
        (state_q == S_RAMP_UP || state_q == S_RUN || state_q == S_RAMP_DOWN)) begin
      drive_en_d = (pcnt_q < duty_q);
    end
  end

  // Free-running PWM period counter.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pcnt_q <= 16'd0;
    end else if (wrap) begin
      pcnt_q <= 16'd0;
    end else begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  // Registered wheel enables; both wheels share one duty, steering comes from dir.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pwm_l_q <= 1'b0;
      pwm_r_q <= 1'b0;
    end else begin
      pwm_l_q <= drive_en_d;
      pwm_r_q <= drive_en_d;
    end
  end

  // Drive sequencing FSM: duty, latched direction, dead-time counter and busy flag.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      duty_q     <= 16'd0;
      dead_cnt_q <= 16'd0;
      dir_l_q    <= 1'b1;
      dir_r_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else if (overwrite) begin
      // Counter is held at zero so the dead time starts when overwrite drops.
      state_q    <= S_DEAD;
      duty_q     <= 16'd0;
      dead_cnt_q <= 16'd0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          duty_q <= 16'd0;
          if (tgt_valid_d) begin
            // The only place direction may change: nothing is driving here.
            {dir_l_q, dir_r_q} <= tgt_dir_d;
            state_q            <= S_RAMP_UP;
            busy_q             <= 1'b1;
          end
        end
        S_RAMP_UP: begin
          if (!tgt_match) begin
            state_q <= S_RAMP_DOWN;
          end else if (wrap) begin
            duty_q <= duty_up_d;
            if (duty_up_d == DUTY_TOP) begin
              state_q <= S_RUN;
              busy_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (!tgt_match) begin
            state_q <= S_RAMP_DOWN;
            busy_q  <= 1'b1;
          end
        end
        S_RAMP_DOWN: begin
          if (tgt_match) begin
            state_q <= S_RAMP_UP;
          end else if (wrap) begin
            duty_q <= duty_dn_d;
            if (duty_dn_d == 16'd0) begin
              state_q    <= S_DEAD;
              dead_cnt_q <= 16'd0;
            end
          end
        end
        S_DEAD: begin
          if (dead_cnt_q >= DEAD_LAST) begin
            state_q    <= S_IDLE;
            dead_cnt_q <= 16'd0;
            busy_q     <= 1'b0;
          end else begin
            dead_cnt_q <= dead_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          duty_q     <= 16'd0;
          dead_cnt_q <= 16'd0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_l       = pwm_l_q;
  assign pwm_r       = pwm_r_q;
  assign dir_l       = dir_l_q;
  assign dir_r       = dir_r_q;
  assign duty        = duty_q;
  assign drive_state = state_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_motor_driver.sv
// Bench for motor_driver with small timing parameters; an abstract
// per-cycle reference model predicts every output.
module tb_motor_driver;

  localparam int P     = 10;
  localparam int DMAX  = 8;
  localparam int STEP  = 4;
  localparam int DEADC = 3;

  localparam int ST_IDLE = 0;
  localparam int ST_UP   = 1;
  localparam int ST_RUN  = 2;
  localparam int ST_DOWN = 3;
  localparam int ST_DEAD = 4;

  localparam logic [23:0] RST_VEC = {2'b00, 2'b11, 16'd0, 3'd0, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ms;
  logic        ow;
  logic        pwm_l, pwm_r, dir_l, dir_r;
  logic [15:0] duty;
  logic [2:0]  drive_state;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_state, m_pcnt, m_duty, m_dead, m_dir;
  bit m_pwm;

  motor_driver #(
    .PWM_PERIOD (P),
    .DUTY_MAX   (DMAX),
    .RAMP_STEP  (STEP),
    .DEAD_CYCLES(DEADC)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .motor_state(ms),
    .overwrite  (ow),
    .pwm_l      (pwm_l),
    .pwm_r      (pwm_r),
    .dir_l      (dir_l),
    .dir_r      (dir_r),
    .duty       (duty),
    .drive_state(drive_state),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int target_of(input logic [4:0] code);
    case (code)
      5'd1:    return 3;
      5'd2:    return 1;
      5'd3:    return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_pcnt = 0; m_duty = 0; m_dead = 0; m_pwm = 0; m_dir = 3;
  endtask

  task automatic model_step(input logic [4:0] code, input logic o);
    int tgt;
    bit wrap;
    tgt   = target_of(code);
    wrap  = (m_pcnt == P - 1);
    m_pwm = !o && (m_state == ST_UP || m_state == ST_RUN || m_state == ST_DOWN)
            && (m_pcnt < m_duty);
    m_pcnt = wrap ? 0 : m_pcnt + 1;
    if (o) begin
      m_state = ST_DEAD; m_duty = 0; m_dead = 0;
    end else begin
      case (m_state)
        ST_IDLE: if (tgt >= 0) begin m_dir = tgt; m_state = ST_UP; end
        ST_UP: begin
          if (tgt != m_dir) m_state = ST_DOWN;
          else if (wrap) begin
            m_duty = (m_duty + STEP > DMAX) ? DMAX : m_duty + STEP;
            if (m_duty == DMAX) m_state = ST_RUN;
          end
        end
        ST_RUN: if (tgt != m_dir) m_state = ST_DOWN;
        ST_DOWN: begin
          if (tgt == m_dir) m_state = ST_UP;
          else if (wrap) begin
            m_duty = (m_duty < STEP) ? 0 : m_duty - STEP;
            if (m_duty == 0) begin m_state = ST_DEAD; m_dead = 0; end
          end
        end
        default: begin
          if (m_dead >= DEADC - 1) begin m_state = ST_IDLE; m_dead = 0; end
          else m_dead = m_dead + 1;
        end
      endcase
    end
  endtask

  function automatic logic [23:0] exp_vec();
    logic [1:0] d;
    d = m_dir[1:0];
    return {m_pwm, m_pwm, d, 16'(m_duty), 3'(m_state),
            (m_state == ST_UP || m_state == ST_DOWN || m_state == ST_DEAD)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {pwm_l, pwm_r, dir_l, dir_r, duty, drive_state, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(ms, ow);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin
      n_err++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), RST_VEC);
    end
    @(negedge clk); rst = 1'b0; model_reset();
    for (int i = 0; i < 12; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_forward();
    int first_nz = -1;
    int st_at8 = -1;
    int highs = 0;
    ms = 5'd1;
    for (int i = 0; i < 60 && drive_state !== 3'd2; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL fwd_cycle got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (first_nz < 0 && duty != 0) first_nz = int'(duty);
      if (st_at8 < 0 && duty == 16'd8) st_at8 = int'(drive_state);
    end
    n_cmp++;
    if (drive_state !== 3'd2) begin n_err++; $display("FAIL fwd_reach_run got=%0d exp=2", drive_state); end
    n_cmp++;
    if (first_nz != 4) begin n_err++; $display("FAIL fwd_first_duty got=%0d exp=4", first_nz); end
    n_cmp++;
    if (st_at8 != 2) begin n_err++; $display("FAIL fwd_state_at8 got=%0d exp=2", st_at8); end
    tick();
    for (int i = 0; i < 10; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL fwd_run got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (pwm_l === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 8) begin n_err++; $display("FAIL fwd_pwm_high got=%0d exp=8", highs); end
    n_cmp++;
    if ({dir_l, dir_r} !== 2'b11) begin n_err++; $display("FAIL fwd_dir got=%b exp=11", {dir_l, dir_r}); end
  endtask

  task automatic test_turn_left();
    logic [1:0] prev_dir;
    logic       prev_pwm;
    bit seen_idle = 0;
    bit seen_dn4 = 0;
    int dead_n = 0;
    ms = 5'd2;
    prev_dir = {dir_l, dir_r};
    prev_pwm = pwm_l | pwm_r;
    for (int i = 0; i < 120 && !(seen_idle && drive_state === 3'd2); i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL turn_cycle got=%h exp=%h", dut_vec(), exp_vec());
      end
      if ({dir_l, dir_r} !== prev_dir) begin
        n_cmp++;
        if ((pwm_l | pwm_r | prev_pwm) !== 1'b0) begin
          n_err++; $display("FAIL turn_dir_while_pwm got=1 exp=0");
        end
      end
      if (drive_state === 3'd0) seen_idle = 1;
      if (drive_state === 3'd4) dead_n++;
      if (drive_state === 3'd3 && duty === 16'd4) seen_dn4 = 1;
      prev_dir = {dir_l, dir_r};
      prev_pwm = pwm_l | pwm_r;
    end
    n_cmp++;
    if (drive_state !== 3'd2) begin n_err++; $display("FAIL turn_reach_run got=%0d exp=2", drive_state); end
    n_cmp++;
    if (dead_n != DEADC) begin n_err++; $display("FAIL turn_dead_len got=%0d exp=%0d", dead_n, DEADC); end
    n_cmp++;
    if (!seen_dn4) begin n_err++; $display("FAIL turn_down_duty4 got=0 exp=1"); end
    n_cmp++;
    if ({dir_l, dir_r, duty} !== {2'b01, 16'd8}) begin
      n_err++; $display("FAIL turn_final got=%b/%0d exp=01/8", {dir_l, dir_r}, duty);
    end
  endtask

  task automatic test_overwrite();
    int dead_n;
    ow = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ow_cycle got=%h exp=%h", dut_vec(), exp_vec());
      end
      n_cmp++;
      if ({pwm_l, pwm_r, duty, drive_state} !== {2'b00, 16'd0, 3'd4}) begin
        n_err++; $display("FAIL ow_force got=%b%b/%0d/%0d exp=00/0/4", pwm_l, pwm_r, duty, drive_state);
      end
    end
    ow = 1'b0;
    dead_n = (drive_state === 3'd4) ? 1 : 0;
    for (int i = 0; i < 20 && drive_state === 3'd4; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ow_dead got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (drive_state === 3'd4) dead_n++;
    end
    n_cmp++;
    if (dead_n != DEADC) begin n_err++; $display("FAIL ow_dead_len got=%0d exp=%0d", dead_n, DEADC); end
    for (int i = 0; i < 80 && drive_state !== 3'd2; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ow_reramp got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({drive_state, dir_l, dir_r} !== {3'd2, 2'b01}) begin
      n_err++; $display("FAIL ow_rerun got=%0d/%b exp=2/01", drive_state, {dir_l, dir_r});
    end
  endtask

  task automatic test_rampup_stop();
    ms = 5'd0;
    for (int i = 0; i < 60 && drive_state !== 3'd0; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL stop_to_idle got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    ms = 5'd1;
    for (int i = 0; i < 40 && duty !== 16'd4; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL upstop_ramp got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({drive_state, duty} !== {3'd1, 16'd4}) begin
      n_err++; $display("FAIL upstop_at4 got=%0d/%0d exp=1/4", drive_state, duty);
    end
    ms = 5'd0;
    tick(); n_cmp++;
    if ({drive_state, duty} !== {3'd3, 16'd4}) begin
      n_err++; $display("FAIL upstop_down got=%0d/%0d exp=3/4", drive_state, duty);
    end
    for (int i = 0; i < 40 && drive_state !== 3'd0; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL upstop_cycle got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 15; i++) begin
      tick(); n_cmp++;
      if ({drive_state, duty, pwm_l, pwm_r} !== {3'd0, 16'd0, 2'b00}) begin
        n_err++; $display("FAIL upstop_idle got=%0d/%0d exp=0/0", drive_state, duty);
      end
    end
  endtask

  task automatic test_invalid_and_reset();
    ms = 5'd17;
    for (int i = 0; i < 25; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec() || drive_state !== 3'd0 || pwm_l !== 1'b0) begin
        n_err++; $display("FAIL invalid_idle got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    ms = 5'd1;
    for (int i = 0; i < 40 && duty !== 16'd4; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rst_ramp got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin n_err++; $display("FAIL rst_async got=%h exp=%h", dut_vec(), RST_VEC); end
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin n_err++; $display("FAIL rst_hold got=%h exp=%h", dut_vec(), RST_VEC); end
    @(negedge clk); rst = 1'b0; model_reset();
    for (int i = 0; i < 60 && drive_state !== 3'd2; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rst_reramp got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (drive_state !== 3'd2) begin n_err++; $display("FAIL rst_rerun got=%0d exp=2", drive_state); end
  endtask

  task automatic test_rampdown_return();
    ms = 5'd0;
    for (int i = 0; i < 40 && !(drive_state === 3'd3 && duty === 16'd4); i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ret_down got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({drive_state, duty} !== {3'd3, 16'd4}) begin
      n_err++; $display("FAIL ret_at4 got=%0d/%0d exp=3/4", drive_state, duty);
    end
    ms = 5'd1;
    tick(); n_cmp++;
    if ({drive_state, duty} !== {3'd1, 16'd4}) begin
      n_err++; $display("FAIL ret_up got=%0d/%0d exp=1/4", drive_state, duty);
    end
    for (int i = 0; i < 20 && drive_state !== 3'd2; i++) begin
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ret_cycle got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({drive_state, duty} !== {3'd2, 16'd8}) begin
      n_err++; $display("FAIL ret_run got=%0d/%0d exp=2/8", drive_state, duty);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0:       ms = 5'd0;
          1, 2:    ms = 5'd1;
          3:       ms = 5'd2;
          4:       ms = 5'd3;
          default: ms = 5'($urandom_range(4, 31));
        endcase
        hold = $urandom_range(1, 40);
        ow = ($urandom_range(0, 15) == 0);
      end
      hold--;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin n_err++; $display("FAIL rand_reset got=%h exp=%h", dut_vec(), RST_VEC); end
        @(negedge clk); rst = 1'b0; model_reset();
      end
      tick(); n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rand_cycle i=%0d ms=%0d ow=%b got=%h exp=%h", i, ms, ow, dut_vec(), exp_vec());
      end
    end
    ow = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ms = 5'd0; ow = 1'b0;
    model_reset();
    test_reset();
    test_forward();
    test_turn_left();
    test_overwrite();
    test_rampup_stop();
    test_invalid_and_reset();
    test_rampdown_return();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/motor_driver.md
MOTOR_DRIVER -- requirements
Module: motor_driver

Interface
REQ-001 Parameter PWM_PERIOD, default 1000, is the PWM period in clock cycles; the legal range is 4..65535.
REQ-002 Parameter DUTY_MAX, default 800, is the full-speed duty in cycles and SHALL be less than or equal to PWM_PERIOD.
REQ-003 Parameter RAMP_STEP, default 50, is the duty change applied per PWM period during a ramp.
REQ-004 Parameter DEAD_CYCLES, default 5000, is the number of zero-drive cycles inserted before any direction change.
REQ-005 CLOCK_50  in  1  system clock; all logic is on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 motor_state  in  5  drive command from the robot FSM: 0=STOP, 1=FORWARD, 2=LEFT, 3=RIGHT; any other code is treated as STOP.
REQ-008 overwrite  in  1  emergency stop from the robot FSM; level-sensitive.
REQ-009 pwm_l, pwm_r  out  1 each  left and right wheel PWM enables.
REQ-010 dir_l, dir_r  out  1 each  wheel direction; 1 means forward.
REQ-011 duty  out  16  currently applied duty in cycles.
REQ-012 drive_state  out  3  FSM state encoding: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, DEAD=4.
REQ-013 busy  out  1  high in RAMP_UP, RAMP_DOWN and DEAD.

Function
REQ-014 The direction target SHALL be decoded as follows: FORWARD gives {dir_l, dir_r}=11; LEFT gives 01; RIGHT gives 10; STOP gives no drive.
REQ-015 A free-running period counter pcnt SHALL count 0..PWM_PERIOD-1 and wrap to 0; a "wrap" is the cycle in which pcnt = PWM_PERIOD-1.
REQ-016 pwm_l and pwm_r SHALL be registered and equal to (pcnt < duty) on the following cycle while the FSM is in RAMP_UP, RUN or RAMP_DOWN; they SHALL be 0 in all other states.
REQ-017 duty SHALL change only on a wrap, except for an overwrite or reset forcing it to 0.
REQ-018 IDLE: duty = 0; when the target is not STOP, the FSM SHALL latch the target into dir_l/dir_r and move to RAMP_UP on the next cycle.
REQ-019 RAMP_UP: on each wrap, duty SHALL become min(duty+RAMP_STEP, DUTY_MAX); when the new duty equals DUTY_MAX the FSM SHALL move to RUN.
REQ-020 RUN: duty SHALL be held at DUTY_MAX; a target different from the latched direction (including STOP) SHALL move the FSM to RAMP_DOWN.
REQ-021 RAMP_UP with a changed target SHALL also move to RAMP_DOWN immediately; the duty reached so far is kept as the start point.
REQ-022 RAMP_DOWN: on each wrap, duty SHALL become max(duty-RAMP_STEP, 0) using saturating, non-wrapping subtraction; when it reaches 0 the FSM SHALL move to DEAD.
REQ-023 RAMP_DOWN whose target returns to the latched direction SHALL go back to RAMP_UP from the current duty.
REQ-024 DEAD: a counter SHALL run DEAD_CYCLES cycles and then the FSM SHALL go to IDLE; target changes during DEAD are ignored until IDLE.
REQ-025 overwrite=1 in any state SHALL force duty to 0 and the state to DEAD at the next edge; pwm_l and pwm_r are therefore low from that edge onward.
REQ-026 While overwrite stays high, the DEAD counter SHALL be held at 0; the dead time counts from the cycle overwrite falls.
REQ-027 overwrite has priority over every command, including one arriving in the same cycle.
REQ-028 dir_l and dir_r SHALL change only on the IDLE->RAMP_UP transition, so a direction never reverses while pwm can be high.
REQ-029 All arithmetic SHALL be 16-bit unsigned; duty SHALL never exceed DUTY_MAX and never underflow.

Reset
REQ-030 On reset the FSM SHALL enter IDLE asynchronously, with the following values: pcnt=0, duty=0, DEAD counter=0, pwm_l=pwm_r=0, dir_l=dir_r=1, drive_state=0, busy=0.
REQ-031 Reset asserted mid-ramp or mid-DEAD SHALL drop both PWM outputs at once; after release the block obeys the current motor_state starting from IDLE.

Verification
REQ-032 All bench scenarios use PWM_PERIOD=10, DUTY_MAX=8, RAMP_STEP=4, DEAD_CYCLES=3.
REQ-033 Scenario 1: reset, then motor_state=1 -> state goes IDLE->RAMP_UP; duty goes 4 after the first wrap, then 8 with state RUN; pwm high 8 of every 10 cycles; dir=11.
REQ-034 Scenario 2: in RUN, motor_state=2 -> RAMP_DOWN with duty 4 then 0; DEAD for 3 cycles; IDLE; then dir=01 and ramp to 8; pwm is never high while dir changes.
REQ-035 Scenario 3: in RUN, overwrite=1 for 7 cycles -> duty=0, pwm low from the next edge, state DEAD held for 7 cycles, then 3 more cycles, then IDLE, then re-ramp if motor_state is non-STOP.
REQ-036 Scenario 4: in RAMP_UP at duty=4, motor_state=0 -> RAMP_DOWN, duty 0 at the next wrap, DEAD, IDLE, duty stays 0.
REQ-037 Scenario 5: motor_state=5'd17 (invalid) from IDLE -> the block stays in IDLE and pwm stays 0; reset asserted during RAMP_UP -> all outputs take their reset values immediately.
REQ-038 Scenario 6: in RAMP_DOWN at duty=4, motor_state returns to 1 -> RAMP_UP, duty 8 at the next wrap, RUN.
